// File: rtl/serial_alu_param.sv
// Digit-serial ALU: processes DIGIT bits per clock over a WIDTH-bit operand
// pair behind a start/busy/done handshake, producing a result and ZF/SF/CF/OF.
// Ports:
//   clk, reset (async, active-low)
//   start, opcode[2:0], A, B  - request; latched when busy=0 and opcode!=NOP
//   busy                      - operation in progress
//   done                      - one-cycle pulse, C and flags valid
//   C                         - result (partially updated while busy)
//   ZF, SF, CF, OF            - flags, updated only on the done edge
module serial_alu_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             ZF,
  output logic             SF,
  output logic             CF,
  output logic             OF
);

  localparam int unsigned N   = WIDTH / DIGIT;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW1 = DIGIT + 1;
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d;

  // Current digit datapath
  logic [31:0]      shamt;
  logic [DIGIT-1:0] a_dig, b_dig, b_eff, res_dig;
  logic [DW1-1:0]   sum;
  logic             cout, ovf, is_arith;
  logic [WIDTH-1:0] c_merge;

  always_comb begin
    shamt    = 32'(cnt_q) * 32'(DIGIT);
    a_dig    = DIGIT'(a_q >> shamt);
    b_dig    = DIGIT'(b_q >> shamt);
    // SUB is A + ~B + 1; the +1 comes from carry preset at start
    b_eff    = (op_q == OP_SUB) ? ~b_dig : b_dig;
    sum      = {1'b0, a_dig} + {1'b0, b_eff} + DW1'(carry_q);
    cout     = sum[DIGIT];
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    // Equivalent to carry-into-MSB XOR carry-out on the final digit
    ovf      = (a_dig[DIGIT-1] == b_eff[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);
    case (op_q)
      OP_NOR:          res_dig = ~(a_dig | b_dig);
      OP_XNOR:         res_dig = ~(a_dig ^ b_dig);
      OP_ADD, OP_SUB:  res_dig = sum[DIGIT-1:0];
      OP_AND:          res_dig = a_dig & b_dig;
      OP_OR:           res_dig = a_dig | b_dig;
      OP_XOR:          res_dig = a_dig ^ b_dig;
      default:         res_dig = '0;
    endcase
    c_merge = (c_q & ~(DMASK << shamt)) | (WIDTH'(res_dig) << shamt);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zf_d    = zf_q;
    sf_d    = sf_q;
    cf_d    = cf_q;
    of_d    = of_q;
    case (state_q)
      IDLE: begin
        if (start && (opcode != OP_NOP)) begin
          a_d     = A;
          b_d     = B;
          op_d    = opcode;
          cnt_d   = '0;
          carry_d = (opcode == OP_SUB);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d     = c_merge;
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          zf_d    = (c_merge == '0);
          sf_d    = c_merge[WIDTH-1];
          cf_d    = (op_q == OP_ADD) ? cout : ((op_q == OP_SUB) ? ~cout : 1'b0);
          of_d    = is_arith ? ovf : 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign ZF   = zf_q;
  assign SF   = sf_q;
  assign CF   = cf_q;
  assign OF   = of_q;

endmodule

// File: tb/tb_serial_alu_param.sv
// Bench for serial_alu_param: two instances (DIGIT=1 and DIGIT=4, WIDTH=8),
// a cycle-count/arithmetic reference model, a per-cycle compare process and
// directed operations with literal expected results.
module tb_serial_alu_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       st [2];
  logic [2:0] opc [2];
  logic [7:0] ain [2];
  logic [7:0] bin [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [7:0] c_o [2];
  logic       zf_o [2];
  logic       sf_o [2];
  logic       cf_o [2];
  logic       of_o [2];

  int n_pass = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_alu_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(st[0]), .opcode(opc[0]), .A(ain[0]), .B(bin[0]),
    .busy(busy_o[0]), .done(done_o[0]), .C(c_o[0]),
    .ZF(zf_o[0]), .SF(sf_o[0]), .CF(cf_o[0]), .OF(of_o[0]));

  serial_alu_param #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(st[1]), .opcode(opc[1]), .A(ain[1]), .B(bin[1]),
    .busy(busy_o[1]), .done(done_o[1]), .C(c_o[1]),
    .ZF(zf_o[1]), .SF(sf_o[1]), .CF(cf_o[1]), .OF(of_o[1]));

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Reference result packed as {ZF, SF, CF, OF, C[7:0]}
  function automatic logic [11:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cf, of;
    cf = 1'b0;
    of = 1'b0;
    r  = 8'h00;
    case (op)
      3'd1: r = ~(a | b);
      3'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[7:0];
        cf = s[8];
        of = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd3: r = ~(a ^ b);
      3'd4: begin
        r  = a - b;
        cf = (a < b);
        of = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd5: r = a & b;
      3'd6: r = a | b;
      3'd7: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), r[7], cf, of, r};
  endfunction

  // Model: an accepted op completes N edges later with its arithmetic result
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [11:0] m_res  [2] = '{12'h0, 12'h0};
  logic [11:0] m_pend [2] = '{12'h0, 12'h0};
  int          m_rem  [2] = '{0, 0};

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_res[d]  <= 12'h0;
        m_rem[d]  <= 0;
      end else begin
        m_done[d] <= 1'b0;
        if (m_busy[d]) begin
          if (m_rem[d] == 1) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b1;
            m_res[d]  <= m_pend[d];
          end else begin
            m_rem[d] <= m_rem[d] - 1;
          end
        end else if (st[d] && (opc[d] != 3'd0)) begin
          m_pend[d] <= ref_op(opc[d], ain[d], bin[d]);
          m_rem[d]  <= n_of(d);
          m_busy[d] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
    else
      n_pass++;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, 32'(busy_o[d]), 32'(m_busy[d]));
        chk("done", d, 32'(done_o[d]), 32'(m_done[d]));
        if (!m_busy[d]) chk("C", d, 32'(c_o[d]), 32'(m_res[d][7:0]));
        chk("flags", d, 32'({zf_o[d], sf_o[d], cf_o[d], of_o[d]}), 32'(m_res[d][11:8]));
      end
    end
  end

  // Raise start for one edge; returns at the negedge after that edge
  task automatic issue(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    st[d]  = 1'b1;
    opc[d] = op;
    ain[d] = a;
    bin[d] = b;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int cyc);
    logic ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done_o[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", d, 32'(0), 32'(1));
  endtask

  task automatic run_op(input int d, input logic b2b, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ec, input logic [3:0] ef);
    int cyc;
    if (!b2b) @(negedge clk);
    issue(d, op, a, b);
    wait_done(d, cyc);
    chk("latency", d, 32'(cyc), 32'(n_of(d)));
    chk("C_lit", d, 32'(c_o[d]), 32'(ec));
    chk("flags_lit", d, 32'({zf_o[d], sf_o[d], cf_o[d], of_o[d]}), 32'(ef));
  endtask

  task automatic chk_zero(input string nm, input int d);
    chk(nm, d, 32'({busy_o[d], done_o[d], c_o[d], zf_o[d], sf_o[d], cf_o[d], of_o[d]}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cyc;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; opc[d] = 3'd0; ain[d] = 8'h00; bin[d] = 8'h00;
    end
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset_state", 0);
    chk_zero("reset_state", 1);
    reset = 1'b1;

    // DIGIT=1 arithmetic
    run_op(0, 1'b0, 3'd2, 8'h7F, 8'h01, 8'h80, 4'b0101);
    // Back-to-back: start held in the done cycle
    run_op(0, 1'b1, 3'd2, 8'hFF, 8'h01, 8'h00, 4'b1010);

    // SUB with a start pulse and operand changes mid-RUN
    @(negedge clk);
    issue(0, 3'd4, 8'h05, 8'h07);
    repeat (3) @(negedge clk);
    issue(0, 3'd2, 8'hFF, 8'hFF);
    ain[0] = 8'h11; bin[0] = 8'h22; opc[0] = 3'd5;
    wait_done(0, cyc);
    chk("latency_midpulse", 0, 32'(cyc + 4), 32'(8));
    chk("C_lit", 0, 32'(c_o[0]), 32'(8'hFE));
    chk("flags_lit", 0, 32'({zf_o[0], sf_o[0], cf_o[0], of_o[0]}), 32'(4'b0110));
    run_op(0, 1'b0, 3'd4, 8'h33, 8'h33, 8'h00, 4'b1000);

    // NOP start is ignored
    @(negedge clk);
    issue(0, 3'd0, 8'h12, 8'h34);
    repeat (3) begin
      chk("nop_busy", 0, 32'(busy_o[0]), 32'(0));
      chk("nop_done", 0, 32'(done_o[0]), 32'(0));
      @(negedge clk);
    end

    // DIGIT=4 logic and arithmetic
    run_op(1, 1'b0, 3'd1, 8'hF0, 8'h0F, 8'h00, 4'b1000);
    run_op(1, 1'b0, 3'd3, 8'hF0, 8'h0F, 8'h00, 4'b1000);
    run_op(1, 1'b0, 3'd7, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    run_op(1, 1'b0, 3'd5, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    run_op(1, 1'b1, 3'd6, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    run_op(1, 1'b0, 3'd4, 8'h80, 8'h01, 8'h7F, 4'b0001);
    run_op(1, 1'b0, 3'd2, 8'h8F, 8'h91, 8'h20, 4'b0011);

    // Asynchronous reset in cycle 3 of a DIGIT=1 ADD
    @(negedge clk);
    issue(0, 3'd2, 8'h55, 8'h22);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_zero("async_reset", 0);
    chk_zero("async_reset", 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_reset", 0, 32'(done_o[0]), 32'(0));
    end
    run_op(0, 1'b0, 3'd2, 8'h10, 8'h20, 8'h30, 4'b0000);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
